// File: rtl/alu_wrapper.sv
// Execute-stage ALU: opcode decode, 32-bit combinational result, and the
// registered N/Z condition flags consumed by the branch unit.

module alu_core (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    output logic [31:0] result,
    output logic        set_flags
);

    localparam logic [4:0] OPC_ADD   = 5'b00010;
    localparam logic [4:0] OPC_ADDI  = 5'b00011;
    localparam logic [4:0] OPC_SUB   = 5'b00100;
    localparam logic [4:0] OPC_SUBI  = 5'b00101;
    localparam logic [4:0] OPC_MUL   = 5'b00110;
    localparam logic [4:0] OPC_MOVEH = 5'b00111;
    localparam logic [4:0] OPC_DIV   = 5'b01000;
    localparam logic [4:0] OPC_AND   = 5'b01010;
    localparam logic [4:0] OPC_ANDI  = 5'b01011;
    localparam logic [4:0] OPC_OR    = 5'b01100;
    localparam logic [4:0] OPC_ORI   = 5'b01101;
    localparam logic [4:0] OPC_NOT   = 5'b01110;
    localparam logic [4:0] OPC_XOR   = 5'b10000;
    localparam logic [4:0] OPC_XORI  = 5'b10001;
    localparam logic [4:0] OPC_CMP   = 5'b10010;
    localparam logic [4:0] OPC_MOVEL = 5'b11110;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    logic [2:0] op;

    // LD, ST, CALL, RET, RETI and anything unknown fall through to add.
    always_comb begin
        op = OP_ADD;
        case (opcode)
            OPC_SUB, OPC_SUBI, OPC_CMP:               op = OP_SUB;
            OPC_MUL:                                  op = OP_MUL;
            OPC_DIV:                                  op = OP_DIV;
            OPC_AND, OPC_ANDI, OPC_MOVEH, OPC_MOVEL:  op = OP_AND;
            OPC_OR, OPC_ORI:                          op = OP_OR;
            OPC_XOR, OPC_XORI:                        op = OP_XOR;
            OPC_NOT:                                  op = OP_NOT;
            default:                                  op = OP_ADD;
        endcase
    end

    always_comb begin
        set_flags = 1'b0;
        case (opcode)
            OPC_ADD, OPC_ADDI, OPC_SUB, OPC_SUBI, OPC_MUL, OPC_DIV,
            OPC_AND, OPC_ANDI, OPC_OR, OPC_ORI, OPC_NOT,
            OPC_XOR, OPC_XORI, OPC_CMP:               set_flags = 1'b1;
            default:                                  set_flags = 1'b0;
        endcase
    end

    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_MUL: result = a * b;
            OP_DIV: result = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            OP_AND: result = a & b;
            OP_OR:  result = a | b;
            OP_XOR: result = a ^ b;
            OP_NOT: result = ~a;
            default: result = '0;
        endcase
    end

endmodule

module alu_wrapper (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [4:0]  opcode,
    output logic [31:0] alu_out,
    output logic [1:0]  flags
);

    logic set_flags;

    alu_core ALU (
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .result    (alu_out),
        .set_flags (set_flags)
    );

    // flags[1] = N, flags[0] = Z; reset wins over a coincident update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            flags <= 2'b00;
        end else if (set_flags) begin
            flags <= {alu_out[31], (alu_out == 32'd0)};
        end
    end

endmodule

// File: tb/tb_alu_wrapper.sv
// Directed bench for alu_wrapper: expected values go into a scoreboard queue
// as stimulus is driven and are popped when the DUT output is sampled.

module tb_alu_wrapper;

    logic        clk;
    logic        rst_n;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  opcode;
    logic [31:0] alu_out;
    logic [1:0]  flags;

    int checks = 0;
    int errors = 0;

    typedef struct {
        string       tag;
        logic [31:0] exp;
    } sb_t;

    sb_t sb_q[$];

    alu_wrapper dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .a       (a),
        .b       (b),
        .opcode  (opcode),
        .alu_out (alu_out),
        .flags   (flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam int NDEC = 27;
    logic [4:0] dec_opc [0:NDEC-1] = '{
        5'b00010, 5'b00011, 5'b11100, 5'b11101,
        5'b00100, 5'b00101, 5'b10010,
        5'b00110, 5'b01000,
        5'b01010, 5'b01011, 5'b00111, 5'b11110,
        5'b01100, 5'b01101,
        5'b10000, 5'b10001,
        5'b01110,
        5'b11001, 5'b11010, 5'b11011, 5'b00000, 5'b00001,
        5'b01001, 5'b01111, 5'b10011, 5'b11111
    };
    logic [2:0] dec_exp [0:NDEC-1] = '{
        3'b000, 3'b000, 3'b000, 3'b000,
        3'b001, 3'b001, 3'b001,
        3'b010, 3'b011,
        3'b100, 3'b100, 3'b100, 3'b100,
        3'b101, 3'b101,
        3'b110, 3'b110,
        3'b111,
        3'b000, 3'b000, 3'b000, 3'b000, 3'b000,
        3'b000, 3'b000, 3'b000, 3'b000
    };

    task automatic push_exp(input string tag, input logic [31:0] exp);
        sb_t it;
        it.tag = tag;
        it.exp = exp;
        sb_q.push_back(it);
    endtask

    task automatic check_next(input logic [31:0] obs);
        sb_t it;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty observed=%h", obs);
            return;
        end
        it = sb_q.pop_front();
        assert (obs === it.exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", it.tag, obs, it.exp);
        end
    endtask

    task automatic apply(input logic [4:0] opc, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        opcode = opc;
        a      = av;
        b      = bv;
    endtask

    task automatic comb_check(input string tag, input logic [4:0] opc,
                              input logic [31:0] av, input logic [31:0] bv,
                              input logic [31:0] exp);
        apply(opc, av, bv);
        push_exp(tag, exp);
        #1;
        check_next(alu_out);
    endtask

    task automatic flag_step(input string tag, input logic [4:0] opc,
                             input logic [31:0] av, input logic [31:0] bv,
                             input logic [1:0] expf);
        apply(opc, av, bv);
        push_exp(tag, {30'd0, expf});
        @(posedge clk);
        #1;
        check_next({30'd0, flags});
    endtask

    initial begin
        logic [31:0] av;
        logic [31:0] bv;

        rst_n  = 1'b0;
        opcode = 5'b00010;
        a      = 32'd0;
        b      = 32'd0;

        push_exp("reset_flags", 32'd0);
        @(posedge clk);
        #1;
        check_next({30'd0, flags});

        @(negedge clk);
        rst_n = 1'b1;

        // Decode sweep; a wrong op here invalidates everything downstream.
        for (int i = 0; i < NDEC; i++) begin
            apply(dec_opc[i], 32'h0000_0011, 32'h0000_0022);
            push_exp($sformatf("decode_%b", dec_opc[i]), {29'd0, dec_exp[i]});
            repeat (2) @(posedge clk);
            #1;
            check_next({29'd0, dut.ALU.op});
        end
        if (errors != 0) begin
            $display("CHECKS %0d ERRORS %0d", checks, errors);
            $fatal(1, "FAIL decode_sweep aborted");
        end

        comb_check("add_3_4",    5'b00010, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007);
        comb_check("add_wrap",   5'b00010, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
        for (int i = 0; i < 16; i++) begin
            av = 32'hFFFF_FF00 + 32'h0F0F_0F0F * i;
            bv = 32'h1111_1111 * i + 32'd7;
            comb_check($sformatf("add_sweep_%0d", i), 5'b00010, av, bv, av + bv);
        end

        comb_check("sub_0_1",    5'b00100, 32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF);
        comb_check("subi_9_4",   5'b00101, 32'h0000_0009, 32'h0000_0004, 32'h0000_0005);
        comb_check("mul_ovf",    5'b00110, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000);
        comb_check("mul_7_6",    5'b00110, 32'h0000_0007, 32'h0000_0006, 32'h0000_002A);
        comb_check("div_10_3",   5'b01000, 32'h0000_000A, 32'h0000_0003, 32'h0000_0003);
        comb_check("div_by_0",   5'b01000, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF);
        comb_check("not_0",      5'b01110, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF);
        comb_check("and",        5'b01010, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
        comb_check("moveh",      5'b00111, 32'h1234_5678, 32'hFFFF_0000, 32'h1234_0000);
        comb_check("or",         5'b01100, 32'hF0F0_F0F0, 32'h0F00_0F00, 32'hFFF0_FFF0);
        comb_check("xor",        5'b10000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0);
        comb_check("ld_add",     5'b11101, 32'h0000_1000, 32'h0000_0024, 32'h0000_1024);
        comb_check("call_add",   5'b11001, 32'h0000_0010, 32'h0000_0020, 32'h0000_0030);

        // Flags from a clean reset
        apply(5'b00010, 32'd0, 32'd0);
        rst_n = 1'b0;
        push_exp("flags_after_reset", 32'd0);
        @(posedge clk);
        #1;
        check_next({30'd0, flags});
        @(negedge clk);
        rst_n = 1'b1;

        flag_step("cmp_5_5", 5'b10010, 32'd5, 32'd5, 2'b01);
        flag_step("cmp_3_5", 5'b10010, 32'd3, 32'd5, 2'b10);
        for (int i = 0; i < 3; i++)
            flag_step($sformatf("hold_ld_%0d", i), 5'b11101, 32'd0, 32'd0, 2'b10);
        for (int i = 0; i < 3; i++)
            flag_step($sformatf("hold_moveh_%0d", i), 5'b00111, 32'd0, 32'd0, 2'b10);
        flag_step("hold_st",    5'b11100, 32'd0, 32'd0, 2'b10);
        flag_step("hold_call",  5'b11001, 32'd0, 32'd0, 2'b10);
        flag_step("add_1_1",    5'b00010, 32'd1, 32'd1, 2'b00);
        flag_step("not_0_flag", 5'b01110, 32'd0, 32'd0, 2'b10);
        flag_step("xor_zero",   5'b10000, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 2'b01);
        flag_step("cmp_3_5_b",  5'b10010, 32'd3, 32'd5, 2'b10);

        // Reset coincident with a flag-setting CMP: reset must win
        apply(5'b10010, 32'd5, 32'd5);
        rst_n = 1'b0;
        push_exp("rst_alu_out_tracks", 32'd0);
        #1;
        check_next(alu_out);
        push_exp("reset_priority", 32'd0);
        @(posedge clk);
        #1;
        check_next({30'd0, flags});
        comb_check("rst_alu_out_live", 5'b00010, 32'd40, 32'd2, 32'd42);
        @(negedge clk);
        rst_n = 1'b1;

        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
